// File: rtl/csr.sv
// rtl/csr.sv - machine-mode CSR file for the RV64 hart
// Holds the architectural M-mode CSRs, mcycle/minstret, and the interruptor write-back path.
module csr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        timer_int_i,
  input  logic        inst_retire_i,
  input  logic [11:0] csr_raddr_i,
  output logic [63:0] csr_rdata_o,
  input  logic        csr_wen_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [63:0] csr_wdata_i,
  input  logic        clint_mepc_wen_i,
  input  logic [63:0] clint_mepc_wdata_i,
  input  logic        clint_mcause_wen_i,
  input  logic [63:0] clint_mcause_wdata_i,
  input  logic        clint_mstatus_wen_i,
  input  logic [63:0] clint_mstatus_wdata_i,
  output logic [63:0] csr_mtvec_o,
  output logic [63:0] csr_mepc_o,
  output logic [63:0] csr_mstatus_o,
  output logic        global_int_en_o,
  output logic        mtime_int_en_o,
  output logic        mtime_int_pend_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  localparam logic [63:0] MPP_MASK  = 64'h1800;
  localparam logic [63:0] MISA_VAL  = 64'h8000_0000_0000_0100;

  logic [63:0] mstatus;
  logic [63:0] mtvec;
  logic [63:0] mscratch;
  logic [63:0] mepc;
  logic [63:0] mcause;
  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic        mtie;
  logic        mtip;

  logic sw_mstatus, sw_mie, sw_mtvec, sw_mscratch, sw_mepc, sw_mcause, sw_mcycle, sw_minstret;

  assign sw_mstatus  = csr_wen_i && (csr_waddr_i == ADDR_MSTATUS);
  assign sw_mie      = csr_wen_i && (csr_waddr_i == ADDR_MIE);
  assign sw_mtvec    = csr_wen_i && (csr_waddr_i == ADDR_MTVEC);
  assign sw_mscratch = csr_wen_i && (csr_waddr_i == ADDR_MSCRATCH);
  assign sw_mepc     = csr_wen_i && (csr_waddr_i == ADDR_MEPC);
  assign sw_mcause   = csr_wen_i && (csr_waddr_i == ADDR_MCAUSE);
  assign sw_mcycle   = csr_wen_i && (csr_waddr_i == ADDR_MCYCLE);
  assign sw_minstret = csr_wen_i && (csr_waddr_i == ADDR_MINSTRET);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus  <= MPP_MASK;
      mtvec    <= 64'h0;
      mscratch <= 64'h0;
      mepc     <= 64'h0;
      mcause   <= 64'h0;
      mcycle   <= 64'h0;
      minstret <= 64'h0;
      mtie     <= 1'b0;
      mtip     <= 1'b0;
    end else begin
      mtip <= timer_int_i;

      // Interruptor write-backs take priority over a same-cycle CSR instruction.
      if (clint_mstatus_wen_i)
        mstatus <= clint_mstatus_wdata_i | MPP_MASK;
      else if (sw_mstatus)
        mstatus <= csr_wdata_i | MPP_MASK;

      if (clint_mepc_wen_i)
        mepc <= {clint_mepc_wdata_i[63:1], 1'b0};
      else if (sw_mepc)
        mepc <= {csr_wdata_i[63:1], 1'b0};

      if (clint_mcause_wen_i)
        mcause <= clint_mcause_wdata_i;
      else if (sw_mcause)
        mcause <= csr_wdata_i;

      if (sw_mie)
        mtie <= csr_wdata_i[7];
      if (sw_mtvec)
        mtvec <= {csr_wdata_i[63:2], 2'b00};
      if (sw_mscratch)
        mscratch <= csr_wdata_i;

      // A software load replaces the increment for that cycle.
      if (sw_mcycle)
        mcycle <= csr_wdata_i;
      else
        mcycle <= mcycle + 64'd1;

      if (sw_minstret)
        minstret <= csr_wdata_i;
      else if (inst_retire_i)
        minstret <= minstret + 64'd1;
    end
  end

  always_comb begin
    csr_rdata_o = 64'h0;
    case (csr_raddr_i)
      ADDR_MSTATUS:  csr_rdata_o = mstatus;
      ADDR_MISA:     csr_rdata_o = MISA_VAL;
      ADDR_MIE:      csr_rdata_o = {56'h0, mtie, 7'h0};
      ADDR_MTVEC:    csr_rdata_o = mtvec;
      ADDR_MSCRATCH: csr_rdata_o = mscratch;
      ADDR_MEPC:     csr_rdata_o = mepc;
      ADDR_MCAUSE:   csr_rdata_o = mcause;
      ADDR_MIP:      csr_rdata_o = {56'h0, mtip, 7'h0};
      ADDR_MCYCLE:   csr_rdata_o = mcycle;
      ADDR_MINSTRET: csr_rdata_o = minstret;
      ADDR_MHARTID:  csr_rdata_o = 64'h0;
      default:       csr_rdata_o = 64'h0;
    endcase
  end

  assign csr_mtvec_o      = mtvec;
  assign csr_mepc_o       = mepc;
  assign csr_mstatus_o    = mstatus;
  assign global_int_en_o  = mstatus[3];
  assign mtime_int_en_o   = mtie;
  assign mtime_int_pend_o = mtip;

endmodule

// File: tb/tb_csr.sv
// tb/tb_csr.sv - scoreboard bench for csr
// Stimulus queues expected values; a negedge monitor pops and compares them.
module tb_csr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        timer_int_i;
  logic        inst_retire_i;
  logic [11:0] csr_raddr_i;
  logic [63:0] csr_rdata_o;
  logic        csr_wen_i;
  logic [11:0] csr_waddr_i;
  logic [63:0] csr_wdata_i;
  logic        clint_mepc_wen_i;
  logic [63:0] clint_mepc_wdata_i;
  logic        clint_mcause_wen_i;
  logic [63:0] clint_mcause_wdata_i;
  logic        clint_mstatus_wen_i;
  logic [63:0] clint_mstatus_wdata_i;
  logic [63:0] csr_mtvec_o;
  logic [63:0] csr_mepc_o;
  logic [63:0] csr_mstatus_o;
  logic        global_int_en_o;
  logic        mtime_int_en_o;
  logic        mtime_int_pend_o;

  csr dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .timer_int_i           (timer_int_i),
    .inst_retire_i         (inst_retire_i),
    .csr_raddr_i           (csr_raddr_i),
    .csr_rdata_o           (csr_rdata_o),
    .csr_wen_i             (csr_wen_i),
    .csr_waddr_i           (csr_waddr_i),
    .csr_wdata_i           (csr_wdata_i),
    .clint_mepc_wen_i      (clint_mepc_wen_i),
    .clint_mepc_wdata_i    (clint_mepc_wdata_i),
    .clint_mcause_wen_i    (clint_mcause_wen_i),
    .clint_mcause_wdata_i  (clint_mcause_wdata_i),
    .clint_mstatus_wen_i   (clint_mstatus_wen_i),
    .clint_mstatus_wdata_i (clint_mstatus_wdata_i),
    .csr_mtvec_o           (csr_mtvec_o),
    .csr_mepc_o            (csr_mepc_o),
    .csr_mstatus_o         (csr_mstatus_o),
    .global_int_en_o       (global_int_en_o),
    .mtime_int_en_o        (mtime_int_en_o),
    .mtime_int_pend_o      (mtime_int_pend_o)
  );

  always #5 clk = ~clk;

  // Which DUT output an expectation refers to.
  localparam int S_RDATA = 0, S_MTVEC = 1, S_MEPC = 2, S_MSTATUS = 3,
                 S_GIE = 4, S_MTIE = 5, S_PEND = 6;

  int          sel_q[$];
  logic [63:0] exp_q[$];
  string       name_q[$];
  int          total = 0;
  int          bad = 0;

  initial begin
    forever begin
      @(negedge clk);
      while (sel_q.size() > 0) begin
        int          s;
        logic [63:0] e;
        logic [63:0] a;
        string       n;
        s = sel_q.pop_front();
        e = exp_q.pop_front();
        n = name_q.pop_front();
        case (s)
          S_RDATA:   a = csr_rdata_o;
          S_MTVEC:   a = csr_mtvec_o;
          S_MEPC:    a = csr_mepc_o;
          S_MSTATUS: a = csr_mstatus_o;
          S_GIE:     a = {63'h0, global_int_en_o};
          S_MTIE:    a = {63'h0, mtime_int_en_o};
          default:   a = {63'h0, mtime_int_pend_o};
        endcase
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s: got %h expected %h", n, a, e);
        end
      end
    end
  end

  task automatic chk(input int s, input logic [63:0] e, input string n);
    sel_q.push_back(s);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [63:0] e, input string n);
    csr_raddr_i = a;
    chk(S_RDATA, e, n);
    sync();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    csr_wen_i           = 1'b0;
    clint_mepc_wen_i    = 1'b0;
    clint_mcause_wen_i  = 1'b0;
    clint_mstatus_wen_i = 1'b0;
    inst_retire_i       = 1'b0;
  endtask

  task automatic sw_set(input logic [11:0] a, input logic [63:0] d);
    csr_wen_i   = 1'b1;
    csr_waddr_i = a;
    csr_wdata_i = d;
  endtask

  task automatic sw_wr(input logic [11:0] a, input logic [63:0] d);
    sw_set(a, d);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [11:0] addr;
    logic [63:0] val;
  } rv_t;

  rv_t reset_tab[12];

  initial begin
    reset_tab[0]  = '{12'h300, 64'h1800};
    reset_tab[1]  = '{12'h301, 64'h8000_0000_0000_0100};
    reset_tab[2]  = '{12'h304, 64'h0};
    reset_tab[3]  = '{12'h305, 64'h0};
    reset_tab[4]  = '{12'h340, 64'h0};
    reset_tab[5]  = '{12'h341, 64'h0};
    reset_tab[6]  = '{12'h342, 64'h0};
    reset_tab[7]  = '{12'h344, 64'h0};
    reset_tab[8]  = '{12'hB00, 64'h0};
    reset_tab[9]  = '{12'hB02, 64'h0};
    reset_tab[10] = '{12'hF14, 64'h0};
    reset_tab[11] = '{12'h7C0, 64'h0};

    rst_n = 1'b0;
    timer_int_i = 1'b0;
    inst_retire_i = 1'b0;
    csr_raddr_i = 12'h0;
    csr_wen_i = 1'b0;
    csr_waddr_i = 12'h0;
    csr_wdata_i = 64'h0;
    clint_mepc_wen_i = 1'b0;
    clint_mepc_wdata_i = 64'h0;
    clint_mcause_wen_i = 1'b0;
    clint_mcause_wdata_i = 64'h0;
    clint_mstatus_wen_i = 1'b0;
    clint_mstatus_wdata_i = 64'h0;

    // Reset state, read while reset is held so the counters stay at zero.
    tick();
    tick();
    chk(S_MSTATUS, 64'h1800, "rst_mstatus_o");
    chk(S_MTVEC, 64'h0, "rst_mtvec_o");
    chk(S_MEPC, 64'h0, "rst_mepc_o");
    chk(S_GIE, 64'h0, "rst_gie");
    chk(S_MTIE, 64'h0, "rst_mtie");
    chk(S_PEND, 64'h0, "rst_pend");
    for (int i = 0; i < 12; i++)
      rd(reset_tab[i].addr, reset_tab[i].val, $sformatf("rst_rd_%h", reset_tab[i].addr));

    rst_n = 1'b1;
    tick();

    // WARL masking
    sw_wr(12'h305, 64'h8000_0003);
    sw_wr(12'h341, 64'h8000_0005);
    sw_wr(12'h300, 64'h0);
    rd(12'h305, 64'h8000_0000, "warl_mtvec");
    rd(12'h341, 64'h8000_0004, "warl_mepc");
    rd(12'h300, 64'h1800, "warl_mstatus");
    chk(S_MTVEC, 64'h8000_0000, "warl_mtvec_o");
    sw_wr(12'h304, 64'hFFFF);
    chk(S_MTIE, 64'h1, "mie_mtie");
    rd(12'h304, 64'h80, "mie_rd");
    sw_wr(12'h301, 64'h0);
    rd(12'h301, 64'h8000_0000_0000_0100, "misa_ro");
    sw_wr(12'h340, 64'hDEAD_BEEF_0123_4567);
    rd(12'h340, 64'hDEAD_BEEF_0123_4567, "mscratch");
    sw_wr(12'h7C0, 64'h55);
    rd(12'h7C0, 64'h0, "unimpl_wr");

    // Collision: interruptor wins on mepc, mcause commits alongside
    sw_set(12'h341, 64'h1000);
    clint_mepc_wen_i = 1'b1;
    clint_mepc_wdata_i = 64'h2000;
    clint_mcause_wen_i = 1'b1;
    clint_mcause_wdata_i = 64'h8000_0000_0000_0007;
    tick();
    chk(S_MEPC, 64'h2000, "coll_mepc_o");
    rd(12'h341, 64'h2000, "coll_mepc");
    rd(12'h342, 64'h8000_0000_0000_0007, "coll_mcause");
    clint_mstatus_wen_i = 1'b1;
    clint_mstatus_wdata_i = 64'h0;
    tick();
    chk(S_MSTATUS, 64'h1800, "clint_mpp_forced");
    sync();

    // Timer pending: one-cycle lag each way
    tick();
    timer_int_i = 1'b1;
    chk(S_PEND, 64'h0, "pend_lag_rise");
    sync();
    tick();
    chk(S_PEND, 64'h1, "pend_high");
    rd(12'h344, 64'h80, "mip_high");
    sw_wr(12'h344, 64'h0);
    rd(12'h344, 64'h80, "mip_sw_ignored");
    tick();
    timer_int_i = 1'b0;
    chk(S_PEND, 64'h1, "pend_lag_fall");
    sync();
    tick();
    chk(S_PEND, 64'h0, "pend_low");
    rd(12'h344, 64'h0, "mip_low");

    // Counters
    sw_wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
    rd(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE, "mcycle_load");
    tick();
    rd(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, "mcycle_max");
    tick();
    rd(12'hB00, 64'h0, "mcycle_wrap");
    rd(12'hB02, 64'h0, "minstret_idle");
    for (int i = 0; i < 5; i++) begin
      inst_retire_i = 1'b1;
      tick();
      tick();
    end
    rd(12'hB02, 64'd5, "minstret_5");
    inst_retire_i = 1'b1;
    sw_wr(12'hB02, 64'h1234);
    rd(12'hB02, 64'h1234, "minstret_wr_retire");

    // Trap round-trip
    sw_wr(12'h300, 64'h1808);
    chk(S_GIE, 64'h1, "mie_set");
    rd(12'h300, 64'h1808, "mstatus_1808");
    clint_mstatus_wen_i = 1'b1;
    clint_mstatus_wdata_i = 64'h1800;
    clint_mepc_wen_i = 1'b1;
    clint_mepc_wdata_i = 64'h8000_0010;
    clint_mcause_wen_i = 1'b1;
    clint_mcause_wdata_i = 64'd11;
    tick();
    chk(S_GIE, 64'h0, "trap_gie");
    chk(S_MEPC, 64'h8000_0010, "trap_mepc_o");
    rd(12'h342, 64'd11, "trap_mcause");
    clint_mstatus_wen_i = 1'b1;
    clint_mstatus_wdata_i = 64'h1888;
    tick();
    chk(S_GIE, 64'h1, "mret_gie");
    rd(12'h300, 64'h1888, "mret_mstatus");

    // Reset mid-sequence discards the pending write-back
    clint_mepc_wen_i = 1'b1;
    clint_mepc_wdata_i = 64'h5554;
    clint_mcause_wen_i = 1'b1;
    clint_mcause_wdata_i = 64'd3;
    rst_n = 1'b0;
    tick();
    chk(S_MEPC, 64'h0, "rst2_mepc_o");
    chk(S_MSTATUS, 64'h1800, "rst2_mstatus_o");
    chk(S_MTVEC, 64'h0, "rst2_mtvec_o");
    chk(S_GIE, 64'h0, "rst2_gie");
    chk(S_MTIE, 64'h0, "rst2_mtie");
    rd(12'h342, 64'h0, "rst2_mcause");
    rd(12'h340, 64'h0, "rst2_mscratch");
    rd(12'hB02, 64'h0, "rst2_minstret");
    rst_n = 1'b1;
    tick();
    sync();

    if (sel_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sel_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
